mux_nx1_stream: RTL and testbench

- Parametrised N-to-1 selector for WIDTH-bit data with a per-channel valid/ready handshake and a registered output stage.
- Two select modes: fixed select (external sel) and round-robin (fair service of all valid channels).
- Sits between multiple data producers and a single consumer. Successor to the combinational 4x1 multi-bit muxes in the lab library.

---
 rtl/mux_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/mux_nx1_stream.sv | 61 ++++++
 tb/tb_mux_nx1_stream.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and round-robin index helper
package mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    function automatic int rr_index(input int base, input int k, input int n);
        return (base + k >= n) ? base + k - n : base + k;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority search starting at ptr
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);
    always_comb begin
        grant = '0;
        grant_valid = 1'b0;
        // Scan farthest-first so the channel closest to ptr wins last
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req[rr_index(int'(ptr), k, CHANNELS)]) begin
                grant = SEL_W'(rr_index(int'(ptr), k, CHANNELS));
                grant_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N-to-1 stream selector, fixed or round-robin, registered output
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int SEL_N = 1 << SEL_W;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d, ptr_q, ptr_d, rr_grant, grant;
    logic             out_valid_q, out_valid_d, rr_valid, grant_valid, load_en, xfer;
    logic [SEL_N-1:0] valid_ext;
    rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
        .req(in_valid),
        .ptr(ptr_q),
        .grant(rr_grant),
        .grant_valid(rr_valid)
    );
    // Zero-extended valids make out-of-range fixed selects grant nothing
    assign valid_ext = SEL_N'(in_valid);
    always_comb begin
        load_en = !out_valid_q || out_ready;
        grant = (mode == MODE_RR) ? rr_grant : sel;
        grant_valid = (mode == MODE_RR) ? rr_valid : valid_ext[sel];
        xfer = load_en && grant_valid && !rst;
        in_ready = xfer ? CHANNELS'(1) << grant : '0;
        out_data_d = xfer ? in_data[int'(grant)*WIDTH +: WIDTH] : out_data_q;
        out_chan_d = xfer ? grant : out_chan_q;
        out_valid_d = xfer || (out_valid_q && !out_ready);
        ptr_d = !xfer ? ptr_q : (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_chan_q <= '0;
            out_valid_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            out_data_q <= out_data_d;
            out_chan_q <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q <= ptr_d;
        end
    end
    assign out_data = out_data_q;
    assign out_chan = out_chan_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb_mux_nx1_stream: 4- and 3-channel instances against a queue-free reference model
module tb_mux_nx1_stream;
    logic        clk = 0, rst = 1, mode = 1, out_ready = 0;
    logic [1:0]  sel = 0;
    logic [3:0]  v = 4'hf;
    logic [11:0] dat = 0;
    logic [3:0]  rd4;
    logic [2:0]  od4, rd3, od3;
    logic [1:0]  oc4, oc3;
    logic        ov4, ov3;
    int n_tests = 0, n_fail = 0;
    int mptr[2], mod[2], moc[2];
    bit mov[2];
    bit armed = 0;

    always #5 clk = ~clk;

    mux_nx1_stream #(.WIDTH(3), .CHANNELS(4)) d4 (
        .clk(clk), .rst(rst), .in_data(dat), .in_valid(v), .in_ready(rd4),
        .mode(mode), .sel(sel), .out_data(od4), .out_chan(oc4),
        .out_valid(ov4), .out_ready(out_ready)
    );
    mux_nx1_stream #(.WIDTH(3), .CHANNELS(3)) d3 (
        .clk(clk), .rst(rst), .in_data(dat[8:0]), .in_valid(v[2:0]), .in_ready(rd3),
        .mode(mode), .sel(sel), .out_data(od3), .out_chan(oc3),
        .out_valid(ov3), .out_ready(out_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void arb(input int n, input int p, output bit gv, output int g);
        gv = 0;
        g = 0;
        if (mode == 1'b0) begin
            gv = (int'(sel) < n) && v[sel];
            g = int'(sel);
        end else begin
            for (int k = 0; k < n; k++)
                if (!gv && v[(p + k) % n]) begin
                    gv = 1;
                    g = (p + k) % n;
                end
        end
    endfunction

    function automatic int exp_ready(input int m);
        bit gv;
        int g;
        arb(m ? 3 : 4, mptr[m], gv, g);
        return (!rst && (!mov[m] || out_ready) && gv) ? (1 << g) : 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int m = 0; m < 2; m++) begin
                bit gv;
                int g, n;
                n = m ? 3 : 4;
                arb(n, mptr[m], gv, g);
                if (rst) begin
                    mptr[m] = 0; mov[m] = 0; mod[m] = 0; moc[m] = 0;
                end else if ((!mov[m] || out_ready) && gv) begin
                    mod[m] = (int'(dat) >> (3 * g)) & 7;
                    moc[m] = g;
                    mov[m] = 1;
                    mptr[m] = (g + 1) % n;
                end else if (out_ready) begin
                    mov[m] = 0;
                end
            end
            if (rst) armed = 1;
            @(negedge clk);
            #1;
            if (armed) begin
                chk("m_rdy4", 32'(rd4), exp_ready(0));
                chk("m_rdy3", 32'(rd3), exp_ready(1));
                chk("m_ov4", 32'(ov4), 32'(mov[0]));
                chk("m_ov3", 32'(ov3), 32'(mov[1]));
                chk("m_od4", 32'(od4), mod[0]);
                chk("m_od3", 32'(od3), mod[1]);
                chk("m_oc4", 32'(oc4), moc[0]);
                chk("m_oc3", 32'(oc3), moc[1]);
            end
        end
    end

    task automatic drive(input logic r, input logic m, input logic [1:0] s,
                         input logic [3:0] vv, input logic orr);
        @(negedge clk);
        rst = r; mode = m; sel = s; v = vv; out_ready = orr;
    endtask

    initial begin
        drive(1, 1, 0, 4'hf, 1);
        #2;
        chk("rst_rdy4", 32'(rd4), 0);
        chk("rst_ov4", 32'(ov4), 0);
        chk("rst_od4", 32'(od4), 0);
        chk("rst_oc4", 32'(oc4), 0);
        dat = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 0, 4'hf, 1);
            #2;
            chk("rr_rdy4", 32'(rd4), 1 << (i % 4));
            chk("rr_rdy3", 32'(rd3), 1 << (i % 3));
            if (i > 0) begin
                chk("rr_oc4", 32'(oc4), (i - 1) % 4);
                chk("rr_od4", 32'(od4), (i - 1) % 4 + 1);
                chk("rr_oc3", 32'(oc3), (i - 1) % 3);
                chk("rr_od3", 32'(od3), (i - 1) % 3 + 1);
            end
        end
        drive(0, 0, 2, 4'hf, 1);
        dat = {3'd4, 3'd5, 3'd2, 3'd1};
        #2;
        chk("fix_rdy4", 32'(rd4), 4);
        chk("fix_rdy3", 32'(rd3), 4);
        drive(0, 1, 0, 4'b0011, 1);
        #2;
        chk("fix_od4", 32'(od4), 5);
        chk("fix_oc4", 32'(oc4), 2);
        chk("fix_ov4", 32'(ov4), 1);
        chk("sp_rdy4_a", 32'(rd4), 1);
        chk("sp_rdy3_a", 32'(rd3), 1);
        drive(0, 1, 0, 4'b0011, 1);
        #2;
        chk("sp_rdy4_b", 32'(rd4), 2);
        chk("sp_rdy3_b", 32'(rd3), 2);
        chk("sp_oc4", 32'(oc4), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 4'hf, 0);
            #2;
            chk("bp_rdy4", 32'(rd4), 0);
            chk("bp_oc4", 32'(oc4), 1);
            chk("bp_od4", 32'(od4), 2);
            chk("bp_ov4", 32'(ov4), 1);
        end
        drive(0, 1, 0, 4'hf, 1);
        #2;
        chk("bp_rel_rdy4", 32'(rd4), 4);
        chk("bp_rel_rdy3", 32'(rd3), 4);
        drive(0, 0, 3, 4'hf, 1);
        #2;
        chk("nobub_ov4", 32'(ov4), 1);
        chk("nobub_oc4", 32'(oc4), 2);
        chk("nobub_od4", 32'(od4), 5);
        chk("inv_rdy3", 32'(rd3), 0);
        chk("inv_rdy4", 32'(rd4), 8);
        drive(0, 0, 3, 4'hf, 1);
        #2;
        chk("inv_drain_ov3", 32'(ov3), 0);
        chk("inv_oc4", 32'(oc4), 3);
        chk("inv_od4", 32'(od4), 4);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, 1'($urandom), 2'($urandom),
                  4'($urandom), $urandom_range(0, 3) != 0);
            dat = 12'($urandom);
        end
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
